// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle LoongArch core: IF/ID/EXE/MEM/WB sequencing.
// Optional perf counters: define MULTICYCLE_PERF_CNT_EN.
module multicycle_ctrl #(
    parameter int IMEM_LAT = 1,
    parameter int DMEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_cbr,
    input  logic        is_link,
    input  logic        is_alu,
    input  logic        br_taken,
    output logic [2:0]  state,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        rf_we,
    output logic        dsram_we,
    output logic        retire
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_retired
`endif
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_NOP,
        C_LOAD,
        C_STORE,
        C_CBR,
        C_LINK,
        C_ALU
    } cls_t;

    localparam logic [2:0] IF_LAST  = 3'(IMEM_LAT - 1);
    localparam logic [2:0] MEM_LAST = 3'(DMEM_LAT - 1);

    state_t     st;
    logic [2:0] cnt;
    cls_t       cls;
    logic       if_last;
    logic       mem_last;

    // Several flags may be high at once; the first match wins.
    always_comb begin
        cls = C_NOP;
        if (is_load)       cls = C_LOAD;
        else if (is_store) cls = C_STORE;
        else if (is_cbr)   cls = C_CBR;
        else if (is_link)  cls = C_LINK;
        else if (is_alu)   cls = C_ALU;
    end

    assign if_last  = (cnt == IF_LAST);
    assign mem_last = (cnt == MEM_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st  <= S_IF;
            cnt <= 3'd0;
        end else begin
            unique case (st)
                S_IF: begin
                    if (if_last) begin
                        st  <= S_ID;
                        cnt <= 3'd0;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_ID: begin
                    cnt <= 3'd0;
                    if (cls == C_CBR || cls == C_NOP)
                        st <= S_IF;
                    else
                        st <= S_EXE;
                end
                S_EXE: begin
                    cnt <= 3'd0;
                    if (cls == C_LOAD || cls == C_STORE)
                        st <= S_MEM;
                    else
                        st <= S_WB;
                end
                S_MEM: begin
                    if (mem_last) begin
                        cnt <= 3'd0;
                        st  <= (cls == C_STORE) ? S_IF : S_WB;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_WB: begin
                    cnt <= 3'd0;
                    st  <= S_IF;
                end
                default: begin
                    cnt <= 3'd0;
                    st  <= S_IF;
                end
            endcase
        end
    end

    assign state = st;

    // Strobes are gated by reset so nothing writes once reset is seen.
    always_comb begin
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        rf_we    = 1'b0;
        dsram_we = 1'b0;
        retire   = 1'b0;
        if (!reset) begin
            case (st)
                S_IF: ir_we = if_last;
                S_ID: begin
                    if (cls == C_CBR || cls == C_NOP) begin
                        pc_we  = 1'b1;
                        pc_sel = (cls == C_CBR) && br_taken;
                        retire = 1'b1;
                    end
                end
                S_MEM: begin
                    if (cls == C_STORE) begin
                        dsram_we = (cnt == 3'd0);
                        pc_we    = mem_last;
                        retire   = mem_last;
                    end
                end
                S_WB: begin
                    rf_we  = 1'b1;
                    retire = 1'b1;
                    pc_we  = 1'b1;
                    pc_sel = (cls == C_LINK) && br_taken;
                end
                default: ;
            endcase
        end
    end

`ifdef MULTICYCLE_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cycles  <= 32'd0;
            perf_retired <= 32'd0;
        end else begin
            perf_cycles <= perf_cycles + 32'd1;
            if (retire)
                perf_retired <= perf_retired + 32'd1;
        end
    end
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle LoongArch core. It sequences the shared datapath (PC, IR, regfile, ALU, data SRAM) through IF/ID/EXE/MEM/WB, one instruction at a time. It takes decoded instruction-class flags and the branch outcome from the datapath. It drives every architectural write enable, so each instruction retires exactly once.

Parameters:
IMEM_LAT, 1, cycles the inst SRAM needs from address to valid rdata (1..8)
DMEM_LAT, 1, cycles the data SRAM needs per access (1..8)

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-high reset
is_load  input  1  decoded ld.w
is_store  input  1  decoded st.w
is_cbr  input  1  decoded b / beq / bne (no regfile write)
is_link  input  1  decoded bl / jirl (regfile write plus redirect)
is_alu  input  1  decoded ALU/imm/lu12i.w op
br_taken  input  1  datapath redirect condition, sampled where pc_we=1
state  output  3  current state: IF=0, ID=1, EXE=2, MEM=3, WB=4
ir_we  output  1  latch inst_sram_rdata into IR
pc_we  output  1  update PC this cycle
pc_sel  output  1  0=pc+4, 1=branch target; meaningful only when pc_we=1
rf_we  output  1  regfile write strobe
dsram_we  output  1  data SRAM write strobe
retire  output  1  instruction completes this cycle (drives debug_wb_*)

Behaviour:
- Reset, taken asynchronously:
  - state=IF, wait counter=0.
  - All strobes 0: ir_we, pc_we, pc_sel, rf_we, dsram_we, retire.
- The FSM is registered. All outputs are combinational from state, counter and inputs, with no extra register stage.
- Class priority when several flags are high: load > store > cbr > link > alu. If no flag is high, the instruction is treated as a NOP.
- IF state:
  - Held for IMEM_LAT cycles using the counter.
  - ir_we=1 on the last IF cycle only, then go to ID.
- ID state (class flags are valid from IR):
  - cbr or NOP: pc_we=1, pc_sel=br_taken for cbr and 0 for NOP, retire=1, then go to IF.
  - All other classes: go to EXE.
- EXE state (1 cycle):
  - load or store: go to MEM.
  - link or alu: go to WB.
- MEM state:
  - Held for DMEM_LAT cycles.
  - store: dsram_we=1 on the first MEM cycle only. On the last MEM cycle: pc_we=1, pc_sel=0, retire=1, then go to IF.
  - load: dsram_we stays 0. After the last MEM cycle, go to WB.
- WB state (1 cycle):
  - rf_we=1 and retire=1.
  - pc_we=1, with pc_sel=br_taken for link and 0 otherwise.
  - Then go to IF.
- Invariants:
  - pc_we == retire in every cycle; exactly one pulse of each per instruction.
  - rf_we=1 only in WB.
  - dsram_we is never 1 outside MEM.
- Latency in cycles, with IMEM_LAT=I and DMEM_LAT=D:
  - cbr / NOP: I+1
  - alu / link: I+3
  - store: I+2+D
  - load: I+3+D
- Counter:
  - Width clog2(8)=3. It counts 0 up to LAT-1 and clears on every state change.
  - It is never left at a nonzero value across a transition.
- Reset asserted in any state (including mid-MEM or mid-IF wait) returns to IF immediately. No partial write may occur after reset is asserted, because strobes go low combinationally.
- Illegal state encodings 5..7 go to IF on the next clock, with all strobes 0.

Optional Feature:
MULTICYCLE_PERF_CNT_EN
- Defined: adds outputs perf_cycles[31:0] and perf_retired[31:0].
  - perf_cycles increments every non-reset cycle.
  - perf_retired increments on every retire.
  - Both clear on reset and wrap from 0xFFFFFFFF to 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- IMEM_LAT=1, is_alu=1 → state sequence 0,1,2,4,0; rf_we=1 only in WB cycle 4; pc_we/retire once; pc_sel=0.
- IMEM_LAT=1, DMEM_LAT=3, is_load=1 → states 0,1,2,3,3,3,4,0 (7 cycles); dsram_we never 1; rf_we in WB.
- DMEM_LAT=2, is_store=1 → dsram_we single pulse on first MEM cycle; retire on second MEM cycle; rf_we never 1; 5 cycles total.
- is_cbr=1 with br_taken=1, then br_taken=0 → each retires in ID after 2 cycles; pc_sel=1 then 0; no rf_we/dsram_we.
- is_load=1 and is_cbr=1 together → load path taken (priority); no flags set → NOP retires in ID with pc_sel=0.
- Reset pulsed on the second MEM cycle of a store (DMEM_LAT=3) → state=0 and all strobes 0 in the same cycle; no second dsram_we; the following instruction starts cleanly with IF. With MULTICYCLE_PERF_CNT_EN, 10 alu instructions → perf_retired=10, perf_cycles=40.
